// File: rtl/bus_pkg.sv
// Shared types and helpers for the single-outstanding memory-bus initiator.
package bus_pkg;

    typedef enum logic [1:0] {
        WidthByte = 2'd0,
        WidthHalf = 2'd1,
        WidthWord = 2'd2
    } width_e;

    typedef enum logic [1:0] {
        StIdle,
        StStrobe,
        StWaitAck,
        StRespond
    } init_state_e;

    localparam logic [1:0] WidthIllegal = 2'd3;

    function automatic logic is_aligned(input logic [1:0] width, input logic [1:0] addr_lo);
        logic ok;
        case (width)
            WidthHalf: ok = ~addr_lo[0];
            WidthWord: ok = (addr_lo == 2'b00);
            default:   ok = 1'b1;
        endcase
        return ok;
    endfunction

    // Right-aligned load data: keep the accessed bytes, zero- or sign-fill the rest.
    function automatic logic [31:0] extend_load(input logic [31:0] data, input logic [1:0] width,
                                                input logic sign_ext);
        logic [31:0] res;
        case (width)
            WidthByte: res = {{24{sign_ext & data[7]}}, data[7:0]};
            WidthHalf: res = {{16{sign_ext & data[15]}}, data[15:0]};
            default:   res = data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/bus_initiator_if.sv
// Core request/response handshake and memory-bus signals of the initiator.
interface bus_initiator_if;
    import bus_pkg::*;

    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic [1:0]  ReqWidth;
    logic        ReqSigned;
    logic [31:0] ReqAddress;
    logic [31:0] ReqData;
    logic        RespValid;
    logic [31:0] RespData;
    logic        RespError;
    logic        Cycle;
    logic        Strobe;
    logic        ReadWrite;
    logic [1:0]  Width;
    logic [31:0] Address;
    logic [31:0] DataOut;
    logic [31:0] DataIn;
    logic        Acknowledge;
    logic        Stall;

    modport master (
        input  ReqValid, ReqWrite, ReqWidth, ReqSigned, ReqAddress, ReqData,
        input  DataIn, Acknowledge, Stall,
        output ReqReady, RespValid, RespData, RespError,
        output Cycle, Strobe, ReadWrite, Width, Address, DataOut
    );

    modport slave (
        output ReqValid, ReqWrite, ReqWidth, ReqSigned, ReqAddress, ReqData,
        output DataIn, Acknowledge, Stall,
        input  ReqReady, RespValid, RespData, RespError,
        input  Cycle, Strobe, ReadWrite, Width, Address, DataOut
    );

endinterface

// File: rtl/bus_initiator.sv
// Single-outstanding bus master: turns core load/store requests into Cycle/Strobe bus
// transactions and returns exactly one registered response per accepted request.
module bus_initiator
    import bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter bit          CHECK_ALIGN    = 1'b1
) (
    input logic             i_clk,
    input logic             i_rst,
    bus_initiator_if.master io_bus
);

    init_state_e r_state, w_state;
    logic [31:0] r_cnt, w_cnt;
    logic        r_req_ready, w_req_ready;
    logic        r_cycle, w_cycle;
    logic        r_strobe, w_strobe;
    logic        r_rw, w_rw;
    logic [1:0]  r_width, w_width;
    logic [31:0] r_addr, w_addr;
    logic [31:0] r_dout, w_dout;
    logic        r_signed, w_signed;
    logic        r_resp_valid, w_resp_valid;
    logic [31:0] r_resp_data, w_resp_data;
    logic        r_resp_error, w_resp_error;
    logic        w_reject;
    logic        w_done;

    assign w_reject = (io_bus.ReqWidth == WidthIllegal) ||
                      (CHECK_ALIGN && !is_aligned(io_bus.ReqWidth, io_bus.ReqAddress[1:0]));

    always_comb begin
        w_state      = r_state;
        w_cnt        = r_cnt;
        w_req_ready  = 1'b0;
        w_cycle      = r_cycle;
        w_strobe     = r_strobe;
        w_rw         = r_rw;
        w_width      = r_width;
        w_addr       = r_addr;
        w_dout       = r_dout;
        w_signed     = r_signed;
        w_resp_valid = 1'b0;
        w_resp_data  = '0;
        w_resp_error = 1'b0;
        w_done       = 1'b0;

        unique case (r_state)
            StIdle: begin
                w_req_ready = 1'b1;
                if (io_bus.ReqValid) begin
                    w_req_ready = 1'b0;
                    if (w_reject) begin
                        w_state      = StRespond;
                        w_resp_valid = 1'b1;
                        w_resp_error = 1'b1;
                    end else begin
                        w_state  = StStrobe;
                        w_cycle  = 1'b1;
                        w_strobe = 1'b1;
                        w_rw     = io_bus.ReqWrite;
                        w_width  = io_bus.ReqWidth;
                        w_addr   = io_bus.ReqAddress;
                        w_dout   = io_bus.ReqData;
                        w_signed = io_bus.ReqSigned;
                    end
                end
            end
            StStrobe: begin
                if (!io_bus.Stall) begin
                    // A responder may acknowledge on the very edge that takes the strobe.
                    if (io_bus.Acknowledge) begin
                        w_done = 1'b1;
                    end else begin
                        w_state  = StWaitAck;
                        w_strobe = 1'b0;
                        w_cnt    = '0;
                    end
                end
            end
            StWaitAck: begin
                if (io_bus.Acknowledge) begin
                    w_done = 1'b1;
                end else if (TIMEOUT_CYCLES != 0 && r_cnt == TIMEOUT_CYCLES - 1) begin
                    w_state      = StRespond;
                    w_resp_valid = 1'b1;
                    w_resp_error = 1'b1;
                end else begin
                    w_cnt = r_cnt + 32'd1;
                end
            end
            StRespond: begin
                w_state     = StIdle;
                w_req_ready = 1'b1;
            end
            default: w_state = StIdle;
        endcase

        if (w_done) begin
            w_state      = StRespond;
            w_resp_valid = 1'b1;
            w_resp_data  = r_rw ? 32'd0 : extend_load(io_bus.DataIn, r_width, r_signed);
        end

        // Bus outputs are only meaningful while a bus cycle is open.
        if (w_state != StStrobe && w_state != StWaitAck) begin
            w_cycle  = 1'b0;
            w_strobe = 1'b0;
            w_rw     = 1'b0;
            w_width  = '0;
            w_addr   = '0;
            w_dout   = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_req_ready  <= 1'b1;
            r_cycle      <= 1'b0;
            r_strobe     <= 1'b0;
            r_rw         <= 1'b0;
            r_width      <= '0;
            r_addr       <= '0;
            r_dout       <= '0;
            r_signed     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_error <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_cnt        <= w_cnt;
            r_req_ready  <= w_req_ready;
            r_cycle      <= w_cycle;
            r_strobe     <= w_strobe;
            r_rw         <= w_rw;
            r_width      <= w_width;
            r_addr       <= w_addr;
            r_dout       <= w_dout;
            r_signed     <= w_signed;
            r_resp_valid <= w_resp_valid;
            r_resp_data  <= w_resp_data;
            r_resp_error <= w_resp_error;
        end
    end

    assign io_bus.ReqReady  = r_req_ready;
    assign io_bus.RespValid = r_resp_valid;
    assign io_bus.RespData  = r_resp_data;
    assign io_bus.RespError = r_resp_error;
    assign io_bus.Cycle     = r_cycle;
    assign io_bus.Strobe    = r_strobe;
    assign io_bus.ReadWrite = r_rw;
    assign io_bus.Width     = r_width;
    assign io_bus.Address   = r_addr;
    assign io_bus.DataOut   = r_dout;

endmodule

// File: doc/bus_initiator.md
Name: bus_initiator

Overview:
- Single-outstanding bus master that turns core load/store requests into Cycle/Strobe/ReadWrite transactions on the shared memory bus.
- Drives the memory-side bus and collects Acknowledge and read data. Returns one response per request to the core.
- Sits between the core's load/store/fetch path and the memory emulator, or any responder on the same bus.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles in WAIT_ACK before the transaction is aborted with an error. 0 disables the timeout.
- CHECK_ALIGN, 1: when 1, a halfword at an odd address or a word at an address not divisible by 4 is rejected with an error and no bus cycle.

Ports:
- Clock  input  1  system clock, rising edge
- Reset  input  1  asynchronous, active-high reset
- ReqValid  input  1  core request valid
- ReqReady  output  1  request accepted when ReqValid&&ReqReady at a rising edge
- ReqWrite  input  1  1=store, 0=load
- ReqWidth  input  2  0=byte, 1=halfword, 2=word, 3=illegal
- ReqSigned  input  1  sign-extend load data (ignored for stores and word loads)
- ReqAddress  input  32  byte address
- ReqData  input  32  store data, right-aligned
- RespValid  output  1  one-cycle response pulse
- RespData  output  32  load data, right-aligned and extended; 0 for stores and errors
- RespError  output  1  qualifies RespValid: illegal width, misalignment or timeout
- Cycle  output  1  bus cycle active
- Strobe  output  1  bus transfer request
- ReadWrite  output  1  1=write, 0=read
- Width  output  2  bus width
- Address  output  32  bus address
- DataOut  output  32  bus write data
- DataIn  input  32  bus read data, valid while Acknowledge=1
- Acknowledge  input  1  responder completion
- Stall  input  1  responder not accepting Strobe this cycle

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State=IDLE.
  - All outputs 0 except ReqReady=1.
  - Timeout counter 0. Any in-flight transaction is dropped with no response.
- All bus outputs and response outputs are registered.
- IDLE:
  - ReqReady=1. On accept, latch the request.
  - If ReqWidth==3, or CHECK_ALIGN and the address is misaligned, go to RESPOND with RespError=1 and no bus activity.
  - Otherwise go to STROBE.
- STROBE:
  - Cycle=1, Strobe=1; ReadWrite, Width, Address and DataOut come from the latched request.
  - Hold while Stall=1.
  - When Stall=0 at an edge, go to WAIT_ACK with Strobe=0 and Cycle still 1.
  - Acknowledge sampled in the same edge as the accepted strobe completes the transaction directly (go to RESPOND).
- WAIT_ACK:
  - Cycle=1, Strobe=0. The counter increments each cycle.
  - On Acknowledge=1: capture DataIn, drop Cycle, go to RESPOND.
  - If the counter reaches TIMEOUT_CYCLES (nonzero) first: drop Cycle, go to RESPOND with RespError=1.
  - Acknowledge and timeout on the same edge: Acknowledge wins.
- RESPOND:
  - RespValid=1 for exactly one cycle, then IDLE. There is no response backpressure.
  - ReqReady=0 in every state except IDLE.
- Load data formatting, from the captured DataIn:
  - Byte: [7:0].
  - Halfword: [15:0].
  - Word: [31:0].
  - Bits above the width are zero, or replicate the top data bit when ReqSigned=1.
- Store data: DataOut = ReqData as given; the responder selects bytes by Width.
- Nominal latency with no Stall and a 1-cycle ack:
  - accept at edge 0;
  - Strobe high in cycle 1;
  - Acknowledge in cycle 2;
  - RespValid in cycle 3.
- Error path latency: RespValid in the cycle after accept.
- Acknowledge while Cycle=0 is ignored and produces no response.
- Throughput: one request every 4 cycles at best.

Decomposition:
- Shared package bus_pkg:
  - width enum (BYTE=0, HALF=1, WORD=2);
  - initiator state enum (IDLE, STROBE, WAIT_ACK, RESPOND);
  - function for width-based alignment check;
  - function for load extension.
- No sub-module; the timeout counter is inline.

Test Plan:
1. Word store 0xDEADBEEF to 0x100, then word load 0x100, responder = memory emulator -> Cycle/Strobe/ReadWrite=1 on store; load RespValid in cycle 3 after accept with RespData=0xDEADBEEF, RespError=0.
2. Byte 0x80 stored at 0x20, then loads of 0x20 -> ReqSigned=1 returns 0xFFFFFF80; ReqSigned=0 returns 0x00000080. Halfword load of 0x8001 at 0x22 with sign extension -> 0xFFFF8001.
3. Stall held high for 3 cycles -> Strobe stays 1 with stable Address/Width; WAIT_ACK is entered only after Stall=0; correct data is returned.
4. Halfword request at 0x101 with CHECK_ALIGN=1, and separately ReqWidth=3 -> Cycle never asserts; RespValid=1 and RespError=1 in the cycle after accept.
5. Responder never acknowledges, TIMEOUT_CYCLES=16 -> Cycle drops after 16 WAIT_ACK cycles; RespError=1, RespData=0; next request is accepted normally. Repeat with Acknowledge arriving on the timeout edge -> success, no error.
6. Reset asserted mid-WAIT_ACK -> Cycle/Strobe go to 0 immediately; no RespValid; ReqReady=1 after release; a stray Acknowledge after reset is ignored.
